// File: rtl/quad_pkg.sv
// Shared types and constants for the quad flight stack: ESC state encoding,
// the speed word width used by flight control, and the pulse-width scaling.
package quad_pkg;

    typedef enum logic {
        DISARM = 1'b0,
        RUN    = 1'b1
    } esc_state_t;

    // 1 ms at 50 MHz: pulse width at zero throttle.
    localparam int ESC_MIN_PULSE = 50000;
    // Clocks of pulse width added per unit of speed.
    localparam int ESC_SPD_SCALE = 24;
    // Width of the unsigned motor speed word.
    localparam int ESC_SPD_W     = 11;
    // Width of the pulse-width register: MIN_PULSE + 24*2047 fits in 17 bits.
    localparam int ESC_PW_W      = 17;

endpackage

// File: rtl/esc_intf_if.sv
// Flight-control-to-ESC link: speed strobe and kill in, drive pulse and
// status out. The master is flight control, the slave is the ESC interface.
interface esc_intf_if;
    import quad_pkg::*;

    logic                 wrt;
    logic [ESC_SPD_W-1:0] spd;
    logic                 kill;
    logic                 pwm;
    logic                 frm_strt;
    logic                 armed;

    modport master (output wrt, spd, kill, input pwm, frm_strt, armed);
    modport slave  (input wrt, spd, kill, output pwm, frm_strt, armed);

endinterface

// File: rtl/esc_slew.sv
// Combinational next applied speed and next pulse width. The speed moves at
// most SLEW per frame toward the target while running and is forced to 0
// otherwise; comparisons are done one bit wider so cur+SLEW cannot wrap.
module esc_slew
    import quad_pkg::*;
#(
    parameter int SLEW      = 64,
    parameter int MIN_PULSE = ESC_MIN_PULSE
) (
    input  esc_state_t           state_i,
    input  logic [ESC_SPD_W-1:0] tgt_i,
    input  logic [ESC_SPD_W-1:0] cur_i,
    output logic [ESC_SPD_W-1:0] cur_next_o,
    output logic [ESC_PW_W-1:0]  pw_next_o
);

    localparam int                XW     = ESC_SPD_W + 1;
    localparam logic [XW-1:0]     SLEW_X = XW'(SLEW);
    localparam logic [ESC_SPD_W-1:0] SLEW_S = SLEW_X[ESC_SPD_W-1:0];

    logic [XW-1:0]       tgt_x;
    logic [XW-1:0]       cur_x;
    logic [ESC_PW_W-1:0] cur_pw;

    // Slew-limited step toward the target, then scale to pulse width (x24 = x16 + x8).
    always_comb begin
        tgt_x      = {1'b0, tgt_i};
        cur_x      = {1'b0, cur_i};
        cur_next_o = '0;
        if (state_i == RUN) begin
            if (tgt_x > cur_x + SLEW_X) begin
                cur_next_o = cur_i + SLEW_S;
            end else if (cur_x > tgt_x + SLEW_X) begin
                cur_next_o = cur_i - SLEW_S;
            end else begin
                cur_next_o = tgt_i;
            end
        end
        cur_pw    = ESC_PW_W'(cur_next_o);
        pw_next_o = ESC_PW_W'(MIN_PULSE) + (cur_pw << 4) + (cur_pw << 3);
    end

endmodule

// File: rtl/esc_intf.sv
// Single-rotor ESC interface: free-running frame counter, arming FSM,
// per-frame slew-limited speed and a servo-style PWM pulse whose width is
// only ever updated on the frame boundary, so no runt pulses occur.
module esc_intf
    import quad_pkg::*;
#(
    parameter int PERIOD_BITS = 20,
    parameter int MIN_PULSE   = ESC_MIN_PULSE,
    parameter int SLEW        = 64,
    parameter int ARM_FRAMES  = 50
) (
    input  logic      clk,
    input  logic      rst_n,
    esc_intf_if.slave esc
);

    localparam int CMP_W = (PERIOD_BITS > ESC_PW_W) ? PERIOD_BITS : ESC_PW_W;
    localparam int ARM_W = $clog2(ARM_FRAMES) + 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_FRAMES - 1);

    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic [ESC_SPD_W-1:0]   tgt_q, tgt_d;
    logic [ESC_SPD_W-1:0]   cur_q, cur_d;
    logic [ESC_PW_W-1:0]    pw_q, pw_d;
    logic [ARM_W-1:0]       arm_q;
    esc_state_t             state_q;
    logic                   pwm_q, frm_q, armed_q;
    logic                   boundary;

    assign cnt_d    = cnt_q + PERIOD_BITS'(1);
    assign tgt_d    = esc.wrt ? esc.spd : tgt_q;
    assign boundary = &cnt_q;

    esc_slew #(
        .SLEW      (SLEW),
        .MIN_PULSE (MIN_PULSE)
    ) u_slew (
        .state_i    (state_q),
        .tgt_i      (tgt_q),
        .cur_i      (cur_q),
        .cur_next_o (cur_d),
        .pw_next_o  (pw_d)
    );

    // Frame counter wraps naturally; target follows the last write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tgt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
        end
    end

    // Applied speed and pulse width change only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            pw_q  <= ESC_PW_W'(MIN_PULSE);
        end else if (boundary) begin
            cur_q <= cur_d;
            pw_q  <= pw_d;
        end
    end

    // Arming FSM: ARM_FRAMES zero-throttle boundaries before RUN; kill drops to DISARM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISARM;
            arm_q   <= '0;
            armed_q <= 1'b0;
        end else if (esc.kill) begin
            state_q <= DISARM;
            arm_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            case (state_q)
                DISARM: begin
                    if (boundary) begin
                        if (arm_q == ARM_LAST) begin
                            state_q <= RUN;
                            arm_q   <= '0;
                            armed_q <= 1'b1;
                        end else begin
                            arm_q <= arm_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    armed_q <= 1'b1;
                end
                default: begin
                    state_q <= DISARM;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered pulse and frame-start marker, one cycle behind the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
            frm_q <= 1'b0;
        end else begin
            pwm_q <= (CMP_W'(cnt_q) < CMP_W'(pw_q));
            frm_q <= (cnt_q == '0);
        end
    end

    assign esc.pwm      = pwm_q;
    assign esc.frm_strt = frm_q;
    assign esc.armed    = armed_q;

endmodule

// File: tb/tb_esc_intf.sv
// Frame-level bench for esc_intf with a shrunken frame (512 clocks) so many
// frames fit in a short run. Each frame's pwm high time, frame-start pulse
// and armed flag are checked, against a table for directed frames and against
// a per-frame behavioural model for random frames.
module tb_esc_intf;
    import quad_pkg::*;

    localparam int PB    = 9;
    localparam int FRAME = 1 << PB;
    localparam int MINP  = 20;
    localparam int SLEW  = 8;
    localparam int ARMF  = 2;

    typedef struct {
        int          w1_pos;
        logic [10:0] w1_spd;
        int          w2_pos;
        logic [10:0] w2_spd;
        int          k_pos;
        int          exp_hi;
        bit          exp_arm;
    } fvec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    esc_intf_if bus();

    esc_intf #(
        .PERIOD_BITS (PB),
        .MIN_PULSE   (MINP),
        .SLEW        (SLEW),
        .ARM_FRAMES  (ARMF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .esc   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: target, applied speed, disarmed boundaries seen, running flag.
    int m_tgt, m_cur, m_bnds, m_late;
    bit m_run;

    fvec_t tbl[15];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic int slew_ref(input int t, input int c);
        if (t > c + SLEW) return c + SLEW;
        if (c > t + SLEW) return c - SLEW;
        return t;
    endfunction

    function automatic int high_ref(input int c);
        int p;
        p = MINP + ESC_SPD_SCALE * c;
        return (p < FRAME) ? p : FRAME;
    endfunction

    task automatic model_reset();
        m_tgt = 0; m_cur = 0; m_bnds = 0; m_run = 0; m_late = -1;
    endtask

    task automatic model_boundary();
        if (m_run) begin
            m_cur = slew_ref(m_tgt, m_cur);
        end else begin
            m_cur = 0;
            m_bnds++;
            if (m_bnds == ARMF) begin
                m_run  = 1;
                m_bnds = 0;
            end
        end
        if (m_late >= 0) begin
            m_tgt  = m_late;
            m_late = -1;
        end
    endtask

    // A write driven after sample j is seen by the edge where the counter equals j;
    // j == FRAME-1 is the boundary cycle, so it only counts from the next boundary.
    task automatic drive_wrt(input logic [10:0] s, input int j);
        bus.wrt = 1'b1;
        bus.spd = s;
        if (j <= FRAME - 2) m_tgt = int'(s);
        else m_late = int'(s);
    endtask

    task automatic run_frame(input fvec_t v, input bit use_tbl, input int fno);
        int hi, fs, fs1, exp_hi;
        bit arm_s, exp_arm;
        hi = 0; fs = 0; fs1 = 0; arm_s = 0;
        exp_hi = high_ref(m_cur);
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            if (bus.pwm) hi++;
            if (bus.frm_strt) begin
                fs++;
                if (j == 1) fs1 = 1;
            end
            if (j == FRAME - 1) arm_s = bus.armed;
            bus.wrt  = 1'b0;
            bus.kill = 1'b0;
            if (v.k_pos == j) begin
                bus.kill = 1'b1;
                m_run  = 0;
                m_bnds = 0;
            end
            if (v.w1_pos == j) drive_wrt(v.w1_spd, j);
            if (v.w2_pos == j) drive_wrt(v.w2_spd, j);
        end
        exp_arm = m_run;
        if (use_tbl) begin
            chk($sformatf("f%0d_high", fno), hi, v.exp_hi);
            chk($sformatf("f%0d_armed", fno), int'(arm_s), int'(v.exp_arm));
        end else begin
            chk($sformatf("f%0d_high", fno), hi, exp_hi);
            chk($sformatf("f%0d_armed", fno), int'(arm_s), int'(exp_arm));
        end
        chk($sformatf("f%0d_frm_cnt", fno), fs, 1);
        chk($sformatf("f%0d_frm_pos", fno), fs1, 1);
        model_boundary();
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: actual timeout required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        fvec_t v;
        // w1_pos, w1_spd, w2_pos, w2_spd, k_pos, exp_hi, exp_arm
        tbl[0]  = '{100, 11'd18, 0,   11'd0,  0,   20,  1'b0};
        tbl[1]  = '{0,   11'd0,  0,   11'd0,  0,   20,  1'b0};
        tbl[2]  = '{0,   11'd0,  0,   11'd0,  0,   20,  1'b1};
        tbl[3]  = '{0,   11'd0,  0,   11'd0,  0,   212, 1'b1};
        tbl[4]  = '{0,   11'd0,  0,   11'd0,  0,   404, 1'b1};
        tbl[5]  = '{0,   11'd0,  0,   11'd0,  0,   452, 1'b1};
        tbl[6]  = '{511, 11'd20, 0,   11'd0,  0,   452, 1'b1};
        tbl[7]  = '{0,   11'd0,  0,   11'd0,  0,   452, 1'b1};
        tbl[8]  = '{50,  11'd0,  300, 11'd10, 0,   500, 1'b1};
        tbl[9]  = '{0,   11'd0,  0,   11'd0,  0,   308, 1'b1};
        tbl[10] = '{0,   11'd0,  0,   11'd0,  200, 260, 1'b0};
        tbl[11] = '{0,   11'd0,  0,   11'd0,  0,   20,  1'b0};
        tbl[12] = '{0,   11'd0,  0,   11'd0,  0,   20,  1'b1};
        tbl[13] = '{0,   11'd0,  0,   11'd0,  0,   212, 1'b1};
        tbl[14] = '{0,   11'd0,  0,   11'd0,  0,   260, 1'b1};

        bus.wrt = 1'b0; bus.spd = '0; bus.kill = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(bus.pwm), 0);
        chk("rst_frm", int'(bus.frm_strt), 0);
        chk("rst_armed", int'(bus.armed), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_frame(tbl[i], 1'b1, i);

        for (int i = 0; i < 20; i++) begin
            v = '{0, 11'd0, 0, 11'd0, 0, 0, 1'b0};
            if ($urandom_range(0, 3) != 0) begin
                v.w1_pos = $urandom_range(1, FRAME - 1);
                v.w1_spd = 11'($urandom_range(0, 24));
                if (v.w1_pos < FRAME - 1 && $urandom_range(0, 1) == 1) begin
                    v.w2_pos = $urandom_range(v.w1_pos + 1, FRAME - 1);
                    v.w2_spd = 11'($urandom_range(0, 24));
                end
            end
            if ($urandom_range(0, 9) == 0) v.k_pos = $urandom_range(1, FRAME - 20);
            run_frame(v, 1'b0, 15 + i);
        end

        // Reset while the pulse is high: outputs must clear without a clock edge.
        @(negedge clk);
        chk("pre_rst_pwm", int'(bus.pwm), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwm", int'(bus.pwm), 0);
        chk("async_frm", int'(bus.frm_strt), 0);
        chk("async_armed", int'(bus.armed), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) run_frame(tbl[i], 1'b1, 100 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/esc_intf.md
# esc_intf

Single-channel electronic-speed-controller interface for one rotor. It consumes the 11-bit unsigned motor speed produced by flight control (`frnt_spd`/`bck_spd`/`lft_spd`/`rght_spd`) and generates a fixed-period servo-style PWM pulse. The block adds an arming sequence and per-frame slew limiting so the motor sees no abrupt throttle steps. Four instances sit between flight control and the motor pins.

## Interface
- `PERIOD_BITS`, default 20: frame counter width. Frame length is 2^PERIOD_BITS clocks (20.97 ms at 50 MHz).
- `MIN_PULSE`, default 50000: pulse width in clocks at speed 0 (1 ms).
- `SLEW`, default 64: maximum change of the applied speed per frame.
- `ARM_FRAMES`, default 50: number of zero-throttle frames emitted before the block arms.
- Legal parameters satisfy `MIN_PULSE + 24*2047 < 2^PERIOD_BITS`.
- Reset is `rst_n`, asynchronous, active-low; the clock is `clk`.

Ports:
- `clk` in, 1: system clock (50 MHz).
- `rst_n` in, 1: asynchronous active-low reset.
- `wrt` in, 1: strobe; `spd` is valid this cycle.
- `spd` in, 11: target speed, unsigned.
- `kill` in, 1: level; forces the disarmed state.
- `pwm` out, 1: ESC drive pulse, registered.
- `frm_strt` out, 1: one-cycle pulse marking the first cycle of each frame, registered.
- `armed` out, 1: high in the RUN state, registered.

## Operation
- Target register `tgt[10:0]`:
  - Loaded from `spd` on `wrt`, regardless of state.
  - Reset value 0.
- Frame counter `cnt[PERIOD_BITS-1:0]`:
  - Free-running; resets to 0 and wraps from all-ones to 0.
  - The boundary cycle is `cnt == all-ones`.
- State machine:
  - DISARM (reset state): applied speed `cur` is held at 0. The arm counter increments on each boundary. Go to RUN on the boundary where the arm count reaches `ARM_FRAMES-1`.
  - RUN: `cur` updates on each boundary by the slew rule below.
  - Any state with `kill`=1 goes to DISARM on the next clock and clears the arm counter. `cur` becomes 0 at the next boundary, with no slew applied.
  - While `kill` stays high the block remains in DISARM and the arm counter is held at 0.
- Slew rule, evaluated at a boundary in RUN, computed at 12 bits so nothing wraps:
  - `tgt > cur + SLEW` → `cur += SLEW`.
  - `cur > tgt + SLEW` → `cur -= SLEW`.
  - Otherwise `cur = tgt`.
- Pulse width:
  - `pw = MIN_PULSE + 24*cur_next`, 17 bits unsigned, computed as `(cur<<4) + (cur<<3)`.
  - Loaded into the `pw` register only at a boundary.
  - Reset value of `pw` is `MIN_PULSE`.
- PWM:
  - `pwm` on the next clock equals `cnt < pw` in the current cycle.
  - The high time is exactly `pw` clocks per frame.
  - `pw` never changes mid-frame, so there are no runt pulses.
- `frm_strt` on the next clock equals `cnt == 0` in the current cycle.

## Timing
- Reset values:
  - Outputs: `pwm`=0, `frm_strt`=0, `armed`=0.
  - Internal: `cnt`=0, `cur`=0, `tgt`=0, `pw`=MIN_PULSE, arm counter 0, state DISARM.
- The first rising edge after reset release starts frame 0. `pwm` and `frm_strt` go high one cycle later.
- Latency from `wrt` to its effect on `pwm`:
  - `tgt` updates 1 cycle after `wrt`.
  - The value is applied at the next boundary and appears in the following frame.
  - Reaching `tgt` takes ceil(|Δ|/SLEW) frames.
- `wrt` on the boundary cycle itself: the old `tgt` is used for that boundary; the new value takes effect at the next one.
- Multiple `wrt` strobes within one frame: the last one wins.
- `armed` rises 1 cycle after the arming boundary. The first non-zero `pw` is possible at the following boundary.
- `kill` falling edge: the arm sequence restarts, taking `ARM_FRAMES` full boundaries.
- Reset mid-frame: `pwm` drops immediately (asynchronous), and all registers return to their reset values.

## Structure
- Shared package `quad_pkg` holds:
  - `esc_state_t` enum {DISARM, RUN}.
  - Localparams `ESC_MIN_PULSE`, `ESC_SPD_SCALE`=24, `ESC_SPD_W`=11.
  - The package is shared with flight control for the speed width.
- One sub-module, `esc_slew`: combinational slew and pulse-width calculation from `tgt`, `cur` and the state → `cur_next`, `pw_next`. The top level owns all registers and the FSM.

## Test plan
- Reset, `ARM_FRAMES`=2, `wrt` with `spd`=1000 in frame 0:
  - Frames 0–1: `pwm` high for exactly 50000 clocks, `armed`=0.
  - `armed` rises after boundary 1.
- Armed, `tgt`=0, `wrt` `spd`=200 with `SLEW`=64:
  - Successive frame highs are 51536, 53072, 54608, then 54800, then stable.
- Armed at `cur`=2047 with `wrt` `spd`=2047:
  - High time is 99128 clocks.
  - `wrt` `spd`=0 then steps down by 64 per frame to 50000.
- `kill` pulse mid-frame at `cur`=500:
  - The current frame keeps 62000 clocks.
  - The next frame is 50000, `armed`=0 one cycle after `kill`.
  - Re-arming takes `ARM_FRAMES` frames.
- `wrt` on the boundary cycle and twice within one frame (`spd`=10 then 20):
  - The boundary write is deferred one frame.
  - The in-frame writes result in `tgt`=20.
- Assert `rst_n` low mid-pulse: `pwm`, `armed` and `frm_strt` go to 0 asynchronously, and frame 0 restarts after release.
